// File: rtl/uart_tx_if.sv
// Byte-stream handshake plus serial line for the 8N1 UART transmitter.
interface uart_tx_if;
    logic [2:0] uart_ctrl;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_busy;
    logic       rs232_tx;

    modport master (
        output uart_ctrl, tx_data, tx_valid,
        input  tx_ready, tx_done, tx_busy, rs232_tx
    );

    modport slave (
        input  uart_ctrl, tx_data, tx_valid,
        output tx_ready, tx_done, tx_busy, rs232_tx
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, LSB first,
// bit period chosen from five baud divisors when the frame is accepted.
module uart_tx_ctrl #(
    parameter int BPS9600_DIV   = 5208,
    parameter int BPS19200_DIV  = 2604,
    parameter int BPS38400_DIV  = 1302,
    parameter int BPS57600_DIV  = 868,
    parameter int BPS115200_DIV = 434
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [12:0] last_q, last_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        line_q, line_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic        take;

    // Stores DIV-1 so the counter compare needs no subtractor.
    function automatic logic [12:0] bit_last(input logic [2:0] sel);
        case (sel)
            3'd1:    bit_last = 13'(BPS19200_DIV - 1);
            3'd2:    bit_last = 13'(BPS38400_DIV - 1);
            3'd3:    bit_last = 13'(BPS57600_DIV - 1);
            3'd4:    bit_last = 13'(BPS115200_DIV - 1);
            default: bit_last = 13'(BPS9600_DIV - 1);
        endcase
    endfunction

    assign bit_end = (cnt_q == last_q);
    // A byte waiting at the end of the stop bit is taken on that same edge,
    // so held-valid traffic goes out with no idle cycle between frames.
    assign take = tx.tx_valid && (ready_q || (state_q == STOP && bit_end));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        line_d  = line_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            if (bit_end) begin
                cnt_d = '0;
                case (state_q)
                    START: begin
                        state_d = DATA;
                        bit_d   = '0;
                        line_d  = shift_q[0];
                    end
                    DATA: begin
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                            line_d  = 1'b1;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {1'b0, shift_q[7:1]};
                            line_d  = shift_q[1];
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        line_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 13'd1;
            end
        end
        if (take) begin
            state_d = START;
            cnt_d   = '0;
            last_d  = bit_last(tx.uart_ctrl);
            shift_d = tx.tx_data;
            line_d  = 1'b0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            bit_q   <= '0;
            line_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
            line_q  <= line_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign tx.tx_ready = ready_q;
    assign tx.tx_busy  = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.rs232_tx = line_q;

endmodule
